// File: rtl/nfc_pkg.sv
// nfc_pkg: shared geometry and byte-lane mapping for the NFC dual-port RAM
package nfc_pkg;
    localparam int NFC_DEPTH  = 4608;
    localparam int NFC_AW     = 13;
    localparam int NFC_DW     = 16;
    localparam int NFC_LANES  = 2;
    localparam int NFC_LANE_W = 8;
    // wen bit index -> data byte: LO covers [7:0], HI covers [15:8]
    typedef enum int {LANE_LO = 0, LANE_HI = 1} nfc_lane_e;
endpackage

// File: rtl/nfc_dpram_port.sv
// nfc_dpram_port: per-port enable decode, range check and read-first output register
module nfc_dpram_port
    import nfc_pkg::*;
#(
    parameter int DEPTH = NFC_DEPTH,
    parameter int AW    = NFC_AW,
    parameter int DW    = NFC_DW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AW-1:0]        addr_i,
    input  logic                 cen_i,
    input  logic [NFC_LANES-1:0] wen_i,
    input  logic [DW-1:0]        rdata_i,
    output logic                 in_range_o,
    output logic [NFC_LANES-1:0] we_o,
    output logic [DW-1:0]        dout_o
);
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);
    logic          acc;
    logic [DW-1:0] dout_d, dout_q;
    assign acc        = !cen_i && !rst_i;
    assign in_range_o = {1'b0, addr_i} < LIMIT;
    assign we_o       = (acc && in_range_o) ? ~wen_i : '0;
    assign dout_d     = acc ? (in_range_o ? rdata_i : '0) : dout_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) dout_q <= '0;
        else       dout_q <= dout_d;
    end
    assign dout_o = dout_q;
endmodule

// File: rtl/nfc_dpram_4p5x16.sv
// nfc_dpram_4p5x16: 4.5K x 16 true dual-port RAM, read-first, byte writes, port A wins collisions
module nfc_dpram_4p5x16
    import nfc_pkg::*;
#(
    parameter int DEPTH = NFC_DEPTH,
    parameter int AW    = NFC_AW,
    parameter int DW    = NFC_DW
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic [AW-1:0]        dpram_addra,
    input  logic                 dpram_cena,
    input  logic [NFC_LANES-1:0] dpram_wena,
    input  logic [DW-1:0]        dpram_dina,
    output logic [DW-1:0]        dpram_douta,
    input  logic [AW-1:0]        dpram_addrb,
    input  logic                 dpram_cenb,
    input  logic [NFC_LANES-1:0] dpram_wenb,
    input  logic [DW-1:0]        dpram_dinb,
    output logic [DW-1:0]        dpram_doutb
);
    logic [DW-1:0]        mem [DEPTH];
    logic [NFC_LANES-1:0] we_a, we_b;
    logic                 ok_a, ok_b;
    logic [DW-1:0]        rd_a, rd_b;
    assign rd_a = ok_a ? mem[dpram_addra] : '0;
    assign rd_b = ok_b ? mem[dpram_addrb] : '0;
    nfc_dpram_port #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_port_a (
        .clk_i(clka), .rst_i(rsta), .addr_i(dpram_addra), .cen_i(dpram_cena),
        .wen_i(dpram_wena), .rdata_i(rd_a), .in_range_o(ok_a), .we_o(we_a), .dout_o(dpram_douta)
    );
    nfc_dpram_port #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_port_b (
        .clk_i(clka), .rst_i(rsta), .addr_i(dpram_addrb), .cen_i(dpram_cenb),
        .wen_i(dpram_wenb), .rdata_i(rd_b), .in_range_o(ok_b), .we_o(we_b), .dout_o(dpram_doutb)
    );
    // B is written before A so A's byte takes precedence on a same-address collision
    always_ff @(posedge clka) begin
        for (int l = 0; l < NFC_LANES; l++) begin
            if (we_b[l]) mem[dpram_addrb][l*NFC_LANE_W +: NFC_LANE_W] <= dpram_dinb[l*NFC_LANE_W +: NFC_LANE_W];
            if (we_a[l]) mem[dpram_addra][l*NFC_LANE_W +: NFC_LANE_W] <= dpram_dina[l*NFC_LANE_W +: NFC_LANE_W];
        end
    end
endmodule

// File: tb/tb_nfc_dpram_4p5x16.sv
// tb_nfc_dpram_4p5x16: scoreboard bench with a word-level reference model
module tb_nfc_dpram_4p5x16;
    localparam int DEPTH = 4608;
    logic        clka = 1'b0;
    logic        rsta = 1'b1;
    logic [12:0] dpram_addra = '0, dpram_addrb = '0;
    logic        dpram_cena = 1'b1, dpram_cenb = 1'b1;
    logic [1:0]  dpram_wena = 2'b11, dpram_wenb = 2'b11;
    logic [15:0] dpram_dina = '0, dpram_dinb = '0;
    logic [15:0] dpram_douta, dpram_doutb;

    nfc_dpram_4p5x16 dut (
        .clka(clka), .rsta(rsta),
        .dpram_addra(dpram_addra), .dpram_cena(dpram_cena), .dpram_wena(dpram_wena),
        .dpram_dina(dpram_dina), .dpram_douta(dpram_douta),
        .dpram_addrb(dpram_addrb), .dpram_cenb(dpram_cenb), .dpram_wenb(dpram_wenb),
        .dpram_dinb(dpram_dinb), .dpram_doutb(dpram_doutb)
    );

    always #5 clka = ~clka;

    typedef struct {
        logic [15:0] a, b;
        logic        ka, kb;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model[int];
    logic [15:0] last_a = '0, last_b = '0;
    logic        known_a = 1'b1, known_b = 1'b1;
    int          checks = 0, failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_write(input int addr, input logic [1:0] wen, input logic [15:0] d);
        logic [15:0] w;
        w = model.exists(addr) ? model[addr] : 16'h0000;
        if (!wen[0]) w[7:0]  = d[7:0];
        if (!wen[1]) w[15:8] = d[15:8];
        model[addr] = w;
    endtask

    // Expected dout for one port at this edge; known=0 means the word was never written
    task automatic model_read(input logic r, input logic cen, input int addr, input logic [15:0] last,
                              input logic last_k, output logic [15:0] v, output logic k);
        if (r)                      begin v = 16'h0000; k = 1'b1; end
        else if (cen)               begin v = last; k = last_k; end
        else if (addr >= DEPTH)     begin v = 16'h0000; k = 1'b1; end
        else if (model.exists(addr)) begin v = model[addr]; k = 1'b1; end
        else                        begin v = 16'h0000; k = 1'b0; end
    endtask

    task automatic cyc(input string tag, input logic r,
                       input logic ca, input logic [1:0] wa, input int aa, input logic [15:0] da,
                       input logic cb, input logic [1:0] wb, input int ab, input logic [15:0] db);
        exp_t e;
        @(negedge clka);
        rsta = r;
        dpram_cena = ca; dpram_wena = wa; dpram_addra = 13'(aa); dpram_dina = da;
        dpram_cenb = cb; dpram_wenb = wb; dpram_addrb = 13'(ab); dpram_dinb = db;
        model_read(r, ca, aa, last_a, known_a, e.a, e.ka);
        model_read(r, cb, ab, last_b, known_b, e.b, e.kb);
        if (!r) begin
            if (!cb && ab < DEPTH) model_write(ab, wb, db);
            if (!ca && aa < DEPTH) model_write(aa, wa, da);
        end
        last_a = e.a; known_a = e.ka;
        last_b = e.b; known_b = e.kb;
        e.tag = tag;
        sb.push_back(e);
        if (r) begin
            #1;
            chk({tag, "_async_a"}, dpram_douta, 16'h0000);
            chk({tag, "_async_b"}, dpram_doutb, 16'h0000);
        end
    endtask

    task automatic rd_a(input string tag, input int addr);
        cyc(tag, 1'b0, 1'b0, 2'b11, addr, 16'h0, 1'b1, 2'b11, 0, 16'h0);
    endtask

    task automatic wr_a(input string tag, input int addr, input logic [1:0] wen, input logic [15:0] d);
        cyc(tag, 1'b0, 1'b0, wen, addr, d, 1'b1, 2'b11, 0, 16'h0);
    endtask

    task automatic idle(input string tag, input logic r);
        cyc(tag, r, 1'b1, 2'b11, 0, 16'h0, 1'b1, 2'b11, 0, 16'h0);
    endtask

    // Monitor: the RAM presents a result after every edge; compare just after it
    initial begin
        forever begin
            @(posedge clka);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                if (e.ka) chk({e.tag, "_a"}, dpram_douta, e.a);
                if (e.kb) chk({e.tag, "_b"}, dpram_doutb, e.b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("reset_a0", dpram_douta, 16'h0000);
        chk("reset_b0", dpram_doutb, 16'h0000);
        cyc("rst_access", 1'b1, 1'b0, 2'b00, 'h10, 16'hFFFF, 1'b0, 2'b00, 'h11, 16'hFFFF);
        idle("hold_after_rst", 1'b0);
        idle("hold_after_rst2", 1'b0);
        // port A write / read / hold
        wr_a("wr10", 'h10, 2'b00, 16'hA5C3);
        rd_a("rd10", 'h10);
        idle("hold10", 1'b0);
        idle("hold10b", 1'b0);
        // byte lanes
        wr_a("wr20", 'h20, 2'b00, 16'h1234);
        wr_a("wr20_lo", 'h20, 2'b10, 16'hFFEE);
        rd_a("rd20_lo", 'h20);
        wr_a("wr20_hi", 'h20, 2'b01, 16'h9900);
        rd_a("rd20_hi", 'h20);
        // cross-port read-while-write and write collision
        wr_a("wr30_zero", 'h30, 2'b00, 16'h0000);
        cyc("rw30", 1'b0, 1'b0, 2'b00, 'h30, 16'h5555, 1'b0, 2'b11, 'h30, 16'h0);
        cyc("rd30_both", 1'b0, 1'b0, 2'b11, 'h30, 16'h0, 1'b0, 2'b11, 'h30, 16'h0);
        cyc("ww40", 1'b0, 1'b0, 2'b00, 'h40, 16'hAAAA, 1'b0, 2'b00, 'h40, 16'hBBBB);
        cyc("rd40", 1'b0, 1'b0, 2'b11, 'h40, 16'h0, 1'b0, 2'b11, 'h40, 16'h0);
        cyc("ww41_split", 1'b0, 1'b0, 2'b10, 'h41, 16'h00CC, 1'b0, 2'b00, 'h41, 16'hDDDD);
        cyc("rd41", 1'b0, 1'b1, 2'b11, 0, 16'h0, 1'b0, 2'b11, 'h41, 16'h0);
        // range boundary
        wr_a("wr1200", 'h1200, 2'b00, 16'hDEAD);
        rd_a("rd1200", 'h1200);
        wr_a("wr11FF", 'h11FF, 2'b00, 16'hBEEF);
        rd_a("rd11FF", 'h11FF);
        cyc("rdb1FFF", 1'b0, 1'b1, 2'b11, 0, 16'h0, 1'b0, 2'b00, 'h1FFF, 16'h1111);
        // reset pulse during a write
        wr_a("wr50_old", 'h50, 2'b00, 16'h1111);
        rd_a("rd50_pre", 'h50);
        cyc("rst_wr50", 1'b1, 1'b0, 2'b00, 'h50, 16'h7777, 1'b0, 2'b00, 'h50, 16'h7777);
        rd_a("rd50_post", 'h50);
        rd_a("rd10_post", 'h10);
        // randomized traffic over a pre-written window plus out-of-range addresses
        for (int i = 0; i < 16; i++) wr_a("init_win", 'h100 + i, 2'b00, 16'($urandom));
        for (int i = 0; i < 300; i++) begin
            int          aa, ab;
            logic        ca, cb;
            aa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4608, 8191)) : 'h100 + int'($urandom_range(0, 15));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4608, 8191)) : 'h100 + int'($urandom_range(0, 15));
            ca = ($urandom_range(0, 3) == 0);
            cb = ($urandom_range(0, 3) == 0);
            cyc("rand", 1'b0, ca, 2'($urandom), aa, 16'($urandom), cb, 2'($urandom), ab, 16'($urandom));
        end
        for (int i = 0; i < 16; i++)
            cyc("final_win", 1'b0, 1'b0, 2'b11, 'h100 + i, 16'h0, 1'b0, 2'b11, 'h10F - i, 16'h0);
        idle("drain", 1'b0);
        repeat (3) @(posedge clka);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nfc_dpram_4p5x16.md
NFC_DPRAM_4P5X16 -- requirements
Module: nfc_dpram_4p5x16

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4608, meaning number of 16-bit words (4.5K).
REQ-002 The block SHALL have parameter AW, default 13, meaning address width.
REQ-003 The block SHALL have parameter DW, default 16, meaning data width (two byte lanes).
REQ-004 The block SHALL have port clka, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rsta, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port dpram_addra, input, AW, port A word address.
REQ-007 The block SHALL have port dpram_cena, input, 1, port A chip enable, active-low.
REQ-008 The block SHALL have port dpram_wena, input, 2, port A byte write enables, active-low; bit0 = [7:0], bit1 = [15:8].
REQ-009 The block SHALL have port dpram_dina, input, DW, port A write data.
REQ-010 The block SHALL have port dpram_douta, output, DW, port A registered read data.
REQ-011 The block SHALL have ports dpram_addrb, dpram_cenb, dpram_wenb and dpram_dinb as inputs, and dpram_doutb as an output, with the same widths and semantics as port A.

Function
REQ-012 A port SHALL access memory on a clka edge only when its cen = 0 and rsta = 0.
REQ-013 During an access, each byte lane with wen bit = 0 SHALL be written from din; lanes with wen bit = 1 SHALL be unchanged.
REQ-014 Every access SHALL load dout with the pre-edge contents of the addressed word (read-first), including write accesses; latency is 1 cycle.
REQ-015 When cen = 1, dout SHALL hold its last value and memory SHALL be unchanged.
REQ-016 For an address >= DEPTH (4608..8191), writes SHALL be ignored and dout SHALL load 16'h0000.
REQ-017 When both ports write the same byte of the same address on the same edge, port A data SHALL win.
REQ-018 When one port reads an address that the other port writes on the same edge, the reader SHALL get the old data.
REQ-019 Two reads of the same address on the same edge SHALL both return the same stored value.
REQ-020 Memory contents SHALL NOT be initialised; contents are undefined until written.

Reset
REQ-021 While rsta = 1, dpram_douta and dpram_doutb SHALL be 16'h0000 asynchronously, and no memory write SHALL occur.
REQ-022 Memory contents SHALL be preserved across reset.
REQ-023 An access presented on the first edge after rsta falls SHALL execute normally.

Structure
REQ-024 DEPTH, AW and DW defaults and the wen lane mapping SHALL live in the shared package nfc_pkg.
REQ-025 The array SHALL be a single DEPTH x DW register or inferred RAM, with per-lane write enables.
REQ-026 Per-port logic (enable decode, range check, output register) SHALL be one sub-module, nfc_dpram_port, instantiated twice.

Verification
REQ-027 The bench SHALL check reset and hold: rsta = 1 -> douta = doutb = 0000; after rsta falls and with cen = 1 -> outputs stay 0000.
REQ-028 The bench SHALL check write/read on port A: write 0x0010 = A5C3 with wena = 00, then read 0x0010 -> douta = A5C3 one cycle after the read edge; cycles with cena = 1 afterwards -> douta holds.
REQ-029 The bench SHALL check byte lanes: 0x0020 = 1234, then write 0x0020 with wena = 10 and data FFEE -> a read returns 12EE; then write with wena = 01 and data 9900 -> a read returns 99EE.
REQ-030 The bench SHALL check cross-port behaviour: port B reads 0x0030 (old value 0000) while port A writes 5555 to 0x0030 on the same edge -> doutb = 0000, and the next read returns 5555; both ports write 0x0040 (A = AAAA, B = BBBB) -> a read returns AAAA.
REQ-031 The bench SHALL check range handling: write 0x1200 (4608) = DEAD, then read 0x1200 -> 0000, and 0x11FF (4607) is still writable and readable.
REQ-032 The bench SHALL check reset mid-operation: rsta pulses during a write of 0x0050 = 7777 -> outputs go to 0000, 0x0050 keeps its old value, and previously written 0x0010 still reads A5C3.
